legv8_main_control: RTL and testbench

- Multi-cycle main control FSM for the LEGv8 CPU, directly upstream of the ALU control decoder.
- Decodes instruction bits [31:21] and sequences fetch/decode/execute/memory/writeback.
- Produces the 2-bit ALUOp consumed by the ALU control stage, plus the datapath enables and a single-channel memory request/ready handshake.

---
 rtl/legv8_ctrl_pkg.sv | 19 +
 rtl/legv8_opcode_class.sv | 14 +
 rtl/legv8_main_control.sv | 105 ++++++++++
 tb/tb_legv8_main_control.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/legv8_ctrl_pkg.sv
// legv8_ctrl_pkg: opcode/ALUOp constants, state and opcode-class enums for the LEGv8 main control
package legv8_ctrl_pkg;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_CBZ = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EX_R, S_WB_R, S_EX_ADDR,
    S_MEM_RD, S_WB_LD, S_MEM_WR, S_BR_CBZ, S_BR_B
  } state_e;
  typedef enum logic [2:0] {CLS_R, CLS_LD, CLS_ST, CLS_CBZ, CLS_B, CLS_ILL} op_class_e;
endpackage

// File: rtl/legv8_opcode_class.sv
// legv8_opcode_class: combinational classifier of inst[31:21] into instruction classes
module legv8_opcode_class
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] op_i,
  output op_class_e   cls_o
);
  always_comb
    cls_o = (op_i inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) ? CLS_R   :
            (op_i == OP_LDUR)                              ? CLS_LD  :
            (op_i == OP_STUR)                              ? CLS_ST  :
            (op_i[10:3] == OP_CBZ_PFX)                     ? CLS_CBZ :
            (op_i[10:5] == OP_B_PFX)                       ? CLS_B   : CLS_ILL;
endmodule

// File: rtl/legv8_main_control.sv
// legv8_main_control: multi-cycle LEGv8 control FSM with Moore level outputs and Mealy strobes
module legv8_main_control
  import legv8_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 11,
  parameter int ALUOP_W  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] inst31_21,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                Reg2Loc,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                illegal_op
);
  state_e    state_q, state_d;
  op_class_e cls;
  legv8_opcode_class u_cls (.op_i(inst31_21), .cls_o(cls));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  // EX_ADDR re-reads the classifier: the IR is stable from DECODE onward
  always_comb begin
    state_d    = S_IDLE;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ALUOp      = ALUOP_MEM;
    Reg2Loc    = 1'b0;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        state_d  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        illegal_op = cls == CLS_ILL;
        state_d    = (cls == CLS_R)                    ? S_EX_R    :
                     (cls == CLS_LD || cls == CLS_ST)  ? S_EX_ADDR :
                     (cls == CLS_CBZ)                  ? S_BR_CBZ  :
                     (cls == CLS_B)                    ? S_BR_B    : S_FETCH;
      end
      S_EX_R: begin
        ALUOp   = ALUOP_R;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        ALUOp    = ALUOP_R;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_EX_ADDR: begin
        ALUSrc  = 1'b1;
        Reg2Loc = cls == CLS_ST;
        state_d = (cls == CLS_ST) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        ALUSrc  = 1'b1;
        state_d = mem_ready ? S_WB_LD : S_MEM_RD;
      end
      S_WB_LD: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        Reg2Loc = 1'b1;
        state_d = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_BR_CBZ: begin
        ALUOp    = ALUOP_CBZ;
        Reg2Loc  = 1'b1;
        pc_write = zero;
        pc_src   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BR_B: begin
        pc_write = 1'b1;
        pc_src   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_legv8_main_control.sv
// tb_legv8_main_control: per-cycle scoreboard against an instruction-level expansion model
module tb_legv8_main_control;
  logic        clk = 1'b0, reset_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [10:0] inst31_21 = '0;
  logic        mem_req, mem_we, Reg2Loc, ALUSrc, MemtoReg, RegWrite, ir_write, pc_write, pc_src, illegal_op;
  logic [1:0]  ALUOp;
  logic [11:0] obs;
  logic [11:0] exp_q[$];
  int          n_tests = 0, n_fail = 0, cyc_n = 0;
  localparam logic [10:0] R_OPS [4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [11:0] ZV = 12'h000;

  always #5 clk = ~clk;

  legv8_main_control dut (
    .clk(clk), .reset_n(reset_n), .inst31_21(inst31_21), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ALUOp(ALUOp), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .illegal_op(illegal_op)
  );

  assign obs = {mem_req, mem_we, ALUOp, Reg2Loc, ALUSrc, MemtoReg, RegWrite, ir_write, pc_write, pc_src, illegal_op};

  function automatic logic [11:0] v(input logic req, we, input logic [1:0] aop,
                                    input logic r2l, src, m2r, rw, ir, pcw, psrc, ill);
    return {req, we, aop, r2l, src, m2r, rw, ir, pcw, psrc, ill};
  endfunction

  // 0=R 1=LDUR 2=STUR 3=CBZ 4=B 5=illegal
  function automatic int cls_of(input logic [10:0] op);
    if (op inside {R_OPS[0], R_OPS[1], R_OPS[2], R_OPS[3]}) return 0;
    if (op == LDUR) return 1;
    if (op == STUR) return 2;
    if (op[10:3] == 8'b10110100) return 3;
    if (op[10:5] == 6'b000101) return 4;
    return 5;
  endfunction

  function automatic logic noise();
    return ($urandom % 2) == 1;
  endfunction

  task automatic cyc(input logic rn, input logic [10:0] op, input logic z, rdy, input logic [11:0] e);
    @(posedge clk);
    #1;
    reset_n = rn; inst31_21 = op; zero = z; mem_ready = rdy;
    exp_q.push_back(e);
  endtask

  task automatic fetch_decode(input logic [10:0] op, input logic z, input int fw);
    for (int i = 0; i < fw; i++) cyc(1, op, z, 1'b0, v(1,0,2'b00,0,0,0,0,0,0,0,0));
    cyc(1, op, z, 1'b1, v(1,0,2'b00,0,0,0,0,1,1,0,0));
    cyc(1, op, z, noise(), v(0,0,2'b00,0,0,0,0,0,0,0, cls_of(op) == 5));
  endtask

  task automatic run_inst(input logic [10:0] op, input logic z, input int fw, mw);
    fetch_decode(op, z, fw);
    case (cls_of(op))
      0: begin
        cyc(1, op, z, noise(), v(0,0,2'b10,0,0,0,0,0,0,0,0));
        cyc(1, op, z, noise(), v(0,0,2'b10,0,0,0,1,0,0,0,0));
      end
      1: begin
        cyc(1, op, z, noise(), v(0,0,2'b00,0,1,0,0,0,0,0,0));
        for (int i = 0; i < mw; i++) cyc(1, op, z, 1'b0, v(1,0,2'b00,0,1,0,0,0,0,0,0));
        cyc(1, op, z, 1'b1, v(1,0,2'b00,0,1,0,0,0,0,0,0));
        cyc(1, op, z, noise(), v(0,0,2'b00,0,0,1,1,0,0,0,0));
      end
      2: begin
        cyc(1, op, z, noise(), v(0,0,2'b00,1,1,0,0,0,0,0,0));
        for (int i = 0; i < mw; i++) cyc(1, op, z, 1'b0, v(1,1,2'b00,1,0,0,0,0,0,0,0));
        cyc(1, op, z, 1'b1, v(1,1,2'b00,1,0,0,0,0,0,0,0));
      end
      3: cyc(1, op, z, noise(), v(0,0,2'b01,1,0,0,0,0,z,1,0));
      4: cyc(1, op, z, noise(), v(0,0,2'b00,0,0,0,0,0,1,1,0));
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    cyc_n++;
    if (exp_q.size() > 0) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL cycle %0d outputs {req,we,aluop,r2l,src,m2r,rw,ir,pcw,psrc,ill} got %b exp %b (inst %b)",
                 cyc_n, obs, e, inst31_21);
      end
    end
  end

  initial begin
    logic [10:0] op;
    for (int i = 0; i < 3; i++) cyc(0, 11'h000, 1'b0, 1'b1, ZV);
    cyc(1, 11'h000, 1'b0, 1'b1, ZV);
    run_inst(R_OPS[0], 1'b0, 0, 0);
    run_inst(LDUR, 1'b0, 0, 2);
    run_inst(STUR, 1'b0, 0, 0);
    run_inst(11'b10110100101, 1'b1, 0, 0);
    run_inst(11'b10110100010, 1'b0, 0, 0);
    run_inst(11'b11111111111, 1'b0, 0, 0);
    run_inst(11'b00010111010, 1'b0, 1, 0);
    // reset asserted while MEM_WR waits: the write must never complete
    fetch_decode(STUR, 1'b0, 0);
    cyc(1, STUR, 1'b0, 1'b0, v(0,0,2'b00,1,1,0,0,0,0,0,0));
    cyc(1, STUR, 1'b0, 1'b0, v(1,1,2'b00,1,0,0,0,0,0,0,0));
    cyc(0, STUR, 1'b0, 1'b1, ZV);
    cyc(0, STUR, 1'b0, 1'b1, ZV);
    cyc(1, STUR, 1'b0, 1'b1, ZV);
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(5, 0))
        0: op = R_OPS[$urandom_range(3, 0)];
        1: op = LDUR;
        2: op = STUR;
        3: op = {8'b10110100, 3'($urandom)};
        4: op = {6'b000101, 5'($urandom)};
        default: begin
          op = 11'h7FF;
          for (int t = 0; t < 100; t++) begin
            logic [10:0] c;
            c = 11'($urandom);
            if (cls_of(c) == 5) begin
              op = c;
              break;
            end
          end
        end
      endcase
      run_inst(op, noise(), $urandom_range(2, 0), $urandom_range(3, 0));
    end
    repeat (2) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain scoreboard left %0d exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
